// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Program counter and fetch sequencing ahead of a 1-cycle
//                registered instruction memory. Decodes the opcode of the
//                returned word to pick sequential / jump / branch / wait-for-
//                input / halt, with range-checked next PC and a sticky fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int MEM_DEPTH = 800,
    parameter int CNT_W     = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [31:0]      Instruction,
    input  logic             BranchTaken,
    input  logic             InputConfirm,
    output logic [31:0]      ProgramCounter,
    output logic             InstrValid,
    output logic             WaitingInput,
    output logic             Halted,
    output logic             Fault,
    output logic [CNT_W-1:0] RetiredCount
);

    localparam logic [5:0]       c_OP_HALT   = 6'b000001;
    localparam logic [5:0]       c_OP_J      = 6'b000101;
    localparam logic [5:0]       c_OP_BEQ    = 6'b010000;
    localparam logic [5:0]       c_OP_IN     = 6'b001011;
    localparam logic [31:0]      c_MEM_LIMIT = 32'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXEC    = 2'd1,
        S_WAIT_IN = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [31:0]      r_pc;
    logic [31:0]      w_nextPc;
    logic [31:0]      w_pcPlusOne;
    logic [31:0]      w_target;
    logic             w_checkRange;
    logic             w_retire;
    logic             w_setFault;
    logic             r_fault;
    logic [CNT_W-1:0] r_count;

    assign w_pcPlusOne = r_pc + 32'd1;

    // Next-state / next-PC selection; every candidate PC passes one range check
    always_comb begin
        w_nextState  = r_state;
        w_nextPc     = r_pc;
        w_target     = w_pcPlusOne;
        w_checkRange = 1'b0;
        w_retire     = 1'b0;
        w_setFault   = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_nextState = S_EXEC;
            end
            S_EXEC: begin
                case (Instruction[31:26])
                    c_OP_HALT: begin
                        w_nextState = S_HALT;
                        w_retire    = 1'b1;
                    end
                    c_OP_J: begin
                        w_target     = {6'd0, Instruction[25:0]};
                        w_checkRange = 1'b1;
                    end
                    c_OP_BEQ: begin
                        w_target     = BranchTaken ? {16'd0, Instruction[15:0]} : w_pcPlusOne;
                        w_checkRange = 1'b1;
                    end
                    c_OP_IN: begin
                        // Retirement is deferred until the input is confirmed
                        w_nextState = S_WAIT_IN;
                    end
                    default: begin
                        w_checkRange = 1'b1;
                    end
                endcase
            end
            S_WAIT_IN: begin
                if (InputConfirm) begin
                    w_checkRange = 1'b1;
                end
            end
            default: begin
                // HALT is absorbing; only Reset leaves it
                w_nextState = S_HALT;
            end
        endcase

        if (w_checkRange) begin
            if (w_target >= c_MEM_LIMIT) begin
                // PC stays on the offending instruction, which is not retired
                w_setFault  = 1'b1;
                w_nextState = S_HALT;
            end else begin
                w_nextPc    = w_target;
                w_nextState = S_FETCH;
                w_retire    = 1'b1;
            end
        end
    end

    // State, PC, sticky fault and retired counter registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_FETCH;
            r_pc    <= 32'd0;
            r_fault <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
            if (w_setFault) begin
                r_fault <= 1'b1;
            end
            if (w_retire) begin
                r_count <= r_count + c_CNT_ONE;
            end
        end
    end

    assign ProgramCounter = r_pc;
    assign InstrValid     = (r_state == S_EXEC);
    assign WaitingInput   = (r_state == S_WAIT_IN);
    assign Halted         = (r_state == S_HALT);
    assign Fault          = r_fault;
    assign RetiredCount   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. An instruction-level
//                interpreter predicts each executed (PC, retired count) pair;
//                a monitor pops and compares them on every InstrValid cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int MEM_DEPTH = 800;
    localparam int CNT_W     = 16;
    localparam int MAX_STEPS = 1000;

    logic             Clock = 1'b0;
    logic             Reset;
    logic [31:0]      Instruction = 32'd0;
    logic             BranchTaken;
    logic             InputConfirm;
    logic [31:0]      ProgramCounter;
    logic             InstrValid;
    logic             WaitingInput;
    logic             Halted;
    logic             Fault;
    logic [CNT_W-1:0] RetiredCount;

    fetch_sequencer #(.MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Instruction    (Instruction),
        .BranchTaken    (BranchTaken),
        .InputConfirm   (InputConfirm),
        .ProgramCounter (ProgramCounter),
        .InstrValid     (InstrValid),
        .WaitingInput   (WaitingInput),
        .Halted         (Halted),
        .Fault          (Fault),
        .RetiredCount   (RetiredCount)
    );

    always #5 Clock = ~Clock;

    // Program image and per-PC branch outcome
    logic [31:0] mem [MEM_DEPTH];
    logic        btk [MEM_DEPTH];

    typedef struct {
        int pc;
        int cnt;
    } exp_t;

    exp_t expQ[$];
    int   nChecks    = 0;
    int   nFail      = 0;
    int   modelEnd   = 0;   // 0 still running, 1 halted, 2 faulted
    int   finalPc    = 0;
    int   finalCnt   = 0;
    int   nEvents    = 0;
    int   lastCnt    = 0;
    int   waitCycles = 0;
    bit   monEn      = 1'b0;
    bit   icAuto     = 1'b1;
    bit   randWait   = 1'b1;
    int   waitTarget = 0;
    int   wcnt       = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] opJ(input int t);
        return {6'b000101, 26'(t)};
    endfunction
    function automatic logic [31:0] opBeq(input int t);
        return {6'b010000, 10'd0, 16'(t)};
    endfunction
    function automatic logic [31:0] opHalt();
        return {6'b000001, 26'd0};
    endfunction
    function automatic logic [31:0] opIn();
        return {6'b001011, 26'd0};
    endfunction

    // Registered instruction memory: one cycle of latency
    always @(posedge Clock) begin
        Instruction <= mem[(ProgramCounter < 32'(MEM_DEPTH)) ? int'(ProgramCounter) : 0];
    end

    // Input driver: branch outcome per PC, confirm after a chosen wait, stray confirms elsewhere
    always @(negedge Clock) begin
        BranchTaken = InstrValid ? btk[(ProgramCounter < 32'(MEM_DEPTH)) ? int'(ProgramCounter) : 0]
                                 : 1'($urandom);
        if (icAuto) begin
            if (WaitingInput) begin
                if (wcnt >= waitTarget) begin
                    InputConfirm = 1'b1;
                    wcnt = 0;
                end else begin
                    InputConfirm = 1'b0;
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                InputConfirm = ($urandom_range(0, 3) == 0);
                if (randWait) waitTarget = $urandom_range(0, 4);
            end
        end
    end

    // Monitor: compare every executed instruction against the interpreter's prediction
    always @(negedge Clock) begin
        if (monEn && !Reset) begin
            if (InstrValid) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_exec_pc", ProgramCounter, -1);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    chk("exec_pc", ProgramCounter, e.pc);
                    chk("exec_count", RetiredCount, e.cnt);
                    lastCnt = e.cnt;
                end
                chk("exec_flags_exclusive", {WaitingInput, Halted}, 0);
            end
            if (WaitingInput) begin
                waitCycles++;
                chk("wait_count_frozen", RetiredCount, lastCnt);
            end
        end
    end

    // Instruction-level interpreter over the loaded program
    task automatic buildModel();
        int          pc;
        int          cnt;
        longint      nxt;
        logic [31:0] ins;
        bit          isHalt;
        pc = 0;
        cnt = 0;
        modelEnd = 0;
        nEvents = 0;
        expQ.delete();
        for (int s = 0; s < MAX_STEPS && modelEnd == 0; s++) begin
            exp_t e;
            ins = mem[pc];
            e.pc = pc;
            e.cnt = cnt % (1 << CNT_W);
            expQ.push_back(e);
            nEvents++;
            isHalt = 1'b0;
            case (ins[31:26])
                6'b000001: begin isHalt = 1'b1; nxt = pc; end
                6'b000101: nxt = longint'(ins[25:0]);
                6'b010000: nxt = btk[pc] ? longint'(ins[15:0]) : longint'(pc) + 1;
                default:   nxt = longint'(pc) + 1;   // sequential and 'in'
            endcase
            if (isHalt) begin
                cnt++;
                modelEnd = 1;
            end else if (nxt >= MEM_DEPTH) begin
                modelEnd = 2;
            end else begin
                pc = int'(nxt);
                cnt++;
            end
        end
        finalPc = pc;
        finalCnt = cnt % (1 << CNT_W);
    endtask

    task automatic clearMem();
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] = 32'd0;
            btk[i] = 1'b0;
        end
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, "_pc"}, ProgramCounter, 0);
        chk({tag, "_instrvalid"}, InstrValid, 0);
        chk({tag, "_waiting"}, WaitingInput, 0);
        chk({tag, "_halted"}, Halted, 0);
        chk({tag, "_fault"}, Fault, 0);
        chk({tag, "_count"}, RetiredCount, 0);
    endtask

    // Predict, reset for one edge, check reset state, release
    task automatic startProgram();
        buildModel();
        monEn = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        checkResetState("reset");
        lastCnt = 0;
        waitCycles = 0;
        monEn = 1'b1;
        Reset = 1'b0;
    endtask

    // Run until halt (or budget), let it sit 20 cycles, check the end state
    task automatic finishProgram();
        int cyc;
        int budget;
        cyc = 0;
        budget = (modelEnd != 0) ? nEvents * 8 + 50 : 500;
        while (!Halted && cyc < budget) begin
            @(negedge Clock);
            cyc++;
        end
        if (modelEnd != 0) begin
            chk("terminated", Halted, 1);
            repeat (20) @(negedge Clock);
            chk("final_pc", ProgramCounter, finalPc);
            chk("final_count", RetiredCount, finalCnt);
            chk("final_fault", Fault, (modelEnd == 2) ? 1 : 0);
            chk("final_halted", Halted, 1);
            chk("queue_drained", expQ.size(), 0);
        end else begin
            chk("running_no_halt", Halted, 0);
            chk("running_no_fault", Fault, 0);
        end
        monEn = 1'b0;
    endtask

    initial begin
        int seqPc [6];
        int seqIv [6];
        int r;
        int guard;
        seqPc = '{0, 1, 1, 2, 2, 3};
        seqIv = '{1, 0, 1, 0, 1, 0};
        Reset = 1'b1;
        BranchTaken = 1'b0;
        InputConfirm = 1'b0;
        clearMem();

        // Three sequential instructions then halt, with cycle-exact PC / InstrValid
        mem[3] = opHalt();
        startProgram();
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            chk("seq_pc", ProgramCounter, seqPc[i]);
            chk("seq_instrvalid", InstrValid, seqIv[i]);
        end
        chk("seq_count_at_pc3", RetiredCount, 3);
        finishProgram();

        // Jump then branch taken / not taken
        clearMem();
        mem[0] = opJ(4);
        mem[4] = opJ(9);
        mem[9] = opBeq(23);
        mem[10] = opHalt();
        mem[23] = opHalt();
        btk[9] = 1'b1;
        startProgram();
        finishProgram();
        chk("beq_taken_pc", ProgramCounter, 23);
        btk[9] = 1'b0;
        startProgram();
        finishProgram();
        chk("beq_not_taken_pc", ProgramCounter, 10);

        // 'in' at PC 2: confirm withheld 5 WAIT_IN cycles, pulsed in the 6th
        clearMem();
        mem[2] = opIn();
        mem[3] = opHalt();
        randWait = 1'b0;
        waitTarget = 5;
        startProgram();
        finishProgram();
        chk("wait_cycles", waitCycles, 6);
        randWait = 1'b1;

        // Halt at PC 29
        clearMem();
        mem[0] = opJ(29);
        mem[29] = opHalt();
        startProgram();
        finishProgram();

        // Jump out of range, sequential off the end, 'in' confirmed at the last word
        clearMem();
        mem[0] = opJ(800);
        startProgram();
        finishProgram();
        clearMem();
        startProgram();
        finishProgram();
        clearMem();
        mem[0] = opJ(799);
        mem[799] = opIn();
        startProgram();
        finishProgram();

        // Jump to self loops forever, retiring each pass
        clearMem();
        mem[0] = opJ(0);
        startProgram();
        finishProgram();

        // Reset during WAIT_IN with InputConfirm high on the same edge
        clearMem();
        mem[1] = opIn();
        mem[2] = opHalt();
        waitTarget = 1000;
        randWait = 1'b0;
        startProgram();
        guard = 0;
        while (!WaitingInput && guard < 20) begin
            @(negedge Clock);
            guard++;
        end
        chk("reached_wait_in", WaitingInput, 1);
        @(negedge Clock);
        chk("wait_pc", ProgramCounter, 1);
        chk("wait_count", RetiredCount, 1);
        monEn = 1'b0;
        icAuto = 1'b0;
        Reset = 1'b1;
        InputConfirm = 1'b1;
        @(negedge Clock);
        checkResetState("reset_in_wait");
        Reset = 1'b0;
        InputConfirm = 1'b0;
        @(negedge Clock);
        chk("post_reset_exec", InstrValid, 1);
        chk("post_reset_exec_pc", ProgramCounter, 0);
        icAuto = 1'b1;
        randWait = 1'b1;

        // Random programs
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r = $urandom_range(0, 99);
                btk[i] = 1'($urandom);
                if (r < 2)       mem[i] = opHalt();
                else if (r < 12) mem[i] = ($urandom_range(0, 9) == 0) ? {6'b000101, 26'($urandom)}
                                                                      : opJ($urandom_range(0, 819));
                else if (r < 27) mem[i] = {6'b010000, 10'($urandom), 16'($urandom_range(0, 819))};
                else if (r < 35) mem[i] = opIn();
                else             mem[i] = $urandom;
            end
            startProgram();
            finishProgram();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    // Absolute time bound
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch-sequencing stage directly upstream of the instruction memory. Drives the 32-bit `ProgramCounter` into the memory, waits one cycle for the registered `Instruction` to return, and inspects its opcode field to pick the next PC: sequential, jump, taken branch, wait-for-input, or halt. Exposes run/halt/wait status and a retired-instruction counter to the rest of the core and the board I/O.

## Interface
- `MEM_DEPTH`, 800: number of instruction words; valid PCs are 0 .. MEM_DEPTH-1.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `Clock`  in  1  sole clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high; sampled on rising `Clock`.
- `Instruction`  in  32  word returned by instruction memory for the previous `ProgramCounter`.
- `BranchTaken`  in  1  ALU comparison result for the `beq` in EXEC; sampled only in EXEC.
- `InputConfirm`  in  1  user input-accept strobe (debounced, single-cycle).
- `ProgramCounter`  out  32  address presented to instruction memory.
- `InstrValid`  out  1  high for exactly the EXEC cycle; `Instruction` is valid for the core then.
- `WaitingInput`  out  1  high while in WAIT_IN.
- `Halted`  out  1  high while in HALT.
- `Fault`  out  1  sticky; set on PC out of range; cleared only by `Reset`.
- `RetiredCount`  out  CNT_W  instructions completed since reset.

## Operation
- Opcode = `Instruction[31:26]`. Decoded: 000001 halt, 000101 j, 010000 beq, 001011 in; every other value is sequential.
- States: FETCH, EXEC, WAIT_IN, HALT.
- FETCH: `ProgramCounter` stable; next state EXEC unconditionally.
- EXEC: `InstrValid`=1. Next-PC selection:
  - halt: PC unchanged, -> HALT; count increments.
  - j: PC <= zero-extended `Instruction[25:0]`, -> FETCH.
  - beq: if `BranchTaken` PC <= zero-extended `Instruction[15:0]`, else PC+1; -> FETCH.
  - in: PC unchanged, -> WAIT_IN (count not yet incremented).
  - other: PC <= PC+1, -> FETCH.
- WAIT_IN: hold PC; on `InputConfirm`=1, PC <= PC+1, count increments, -> FETCH. `InputConfirm` in any other state is ignored.
- HALT: absorbing; only `Reset` exits.
- Range check: any computed next PC >= MEM_DEPTH -> PC held at current value, `Fault`<=1, -> HALT. The faulting instruction is not counted.
- `RetiredCount` increments by 1 on each EXEC exit to FETCH or HALT (non-fault) and on WAIT_IN exit; wraps modulo 2^CNT_W.
- Arithmetic: PC+1 in 32 bits; targets zero-extended to 32 bits before the range compare.

## Timing
- Reset (highest priority, any state, incl. mid-WAIT_IN): next edge gives state FETCH, `ProgramCounter`=0, `InstrValid`=0, `WaitingInput`=0, `Halted`=0, `Fault`=0, `RetiredCount`=0.
- Every non-`in` instruction occupies 2 cycles (FETCH, EXEC); new PC visible the cycle after EXEC.
- Memory latency is fixed at 1 cycle: the PC value held during FETCH selects the `Instruction` sampled in EXEC; PC never changes between FETCH and EXEC.
- `in`: FETCH, EXEC, >=1 WAIT_IN cycle; `InputConfirm` high in the first WAIT_IN cycle gives PC+1 on the next edge (minimum 3 cycles).
- `WaitingInput`, `Halted`, `InstrValid` are registered state decodes; they rise the cycle the state is entered.
- Branch/jump to self (target = PC) is legal: loops forever, counting each pass.
- Fault and halt in the same EXEC cannot coexist (halt never computes a new PC).

## Test plan
- Reset then 3 sequential opcodes (000000) at PCs 0,1,2 -> `ProgramCounter` sequence 0,0,1,1,2,2,3; `InstrValid` every 2nd cycle; `RetiredCount`=3.
- `j` with `Instruction[25:0]`=9 at PC 4 -> PC=9 after EXEC; then `beq` target 23 with `BranchTaken`=1 -> PC=23; repeat with `BranchTaken`=0 -> PC=10.
- `in` at PC 2, `InputConfirm` held low 5 cycles then pulsed -> `WaitingInput`=1 for 6 cycles, PC goes 2->3, count +1 only after confirm; stray `InputConfirm` in FETCH has no effect.
- `halt` at PC 29 -> `Halted`=1, PC stays 29 for 20 further cycles, count frozen; `Reset` pulse -> PC=0, all flags 0.
- `j` to 800 (MEM_DEPTH=800) and sequential at PC 799 -> `Fault`=1, `Halted`=1, PC holds 799/jump PC, count not incremented.
- `Reset` asserted during WAIT_IN with `InputConfirm` high same cycle -> reset wins: PC=0, `RetiredCount`=0, state FETCH.
